// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the Sudoku game sequencer and its timer.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StLookup,
        StJudge,
        StWon,
        StLost
    } state_e;

    localparam logic [1:0] ST_PLAY = 2'b00;
    localparam logic [1:0] ST_WON  = 2'b01;
    localparam logic [1:0] ST_LOST = 2'b10;

    localparam int unsigned BOARD_CELLS = 81;
    localparam int unsigned BOARD_DIM   = 9;

    // Row-major cell index; only meaningful for row, col <= 8.
    function automatic logic [6:0] cell_addr(input logic [3:0] row, input logic [3:0] col);
        return 7'(row) * 7'(BOARD_DIM) + 7'(col);
    endfunction

endpackage

// File: rtl/game_sequencer_timer.sv
// Game countdown: loads the time limit, decrements on tick while running, saturates at 0.
module game_timer #(
    parameter int unsigned TIME_LIMIT = 600
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic       run,
    input  logic       tick,
    output logic [9:0] time_left,
    output logic       expired
);

    logic [9:0] time_q, time_d;

    always_comb begin
        time_d = time_q;
        if (load) begin
            time_d = 10'(TIME_LIMIT);
        end else if (run && tick && (time_q != '0)) begin
            time_d = time_q - 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            time_q <= '0;
        end else begin
            time_q <= time_d;
        end
    end

    assign time_left = time_q;
    assign expired   = (time_q == '0);

endmodule

// File: rtl/game_sequencer.sv
// Move sequencer: accepts moves, looks up the solution, writes correct digits and
// tracks errors, remaining cells and time until the game is won or lost.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int unsigned MAX_ERRORS = 3,
    parameter int unsigned TIME_LIMIT = 600
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [6:0] blanks_init,
    input  logic       tick,
    input  logic       move_valid,
    input  logic [3:0] move_row,
    input  logic [3:0] move_col,
    input  logic [3:0] move_digit,
    input  logic [3:0] sol_digit,
    input  logic       cell_filled,
    output logic       move_ready,
    output logic [6:0] rd_addr,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [3:0] wr_data,
    output logic [1:0] errors,
    output logic [9:0] time_left,
    output logic [1:0] status,
    output logic       end_enable
);

    state_e     state_q, state_d;
    logic [6:0] remaining_q, remaining_d;
    logic [1:0] errors_q, errors_d;
    logic [6:0] addr_q, addr_d;
    logic [3:0] digit_q, digit_d;
    logic [1:0] status_q, status_d;

    logic       timer_load;
    logic       timer_run;
    logic       expired;
    logic [6:0] move_addr;
    logic       move_ok;

    assign move_addr = cell_addr(move_row, move_col);
    assign move_ok   = (move_row <= 4'd8) && (move_col <= 4'd8) && (move_digit != 4'd0) &&
                       (move_digit <= 4'd9) && ({25'd0, move_addr} < BOARD_CELLS);
    assign timer_run = (state_q == StPlay) || (state_q == StLookup) || (state_q == StJudge);

    game_timer #(
        .TIME_LIMIT(TIME_LIMIT)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (timer_load),
        .run      (timer_run),
        .tick     (tick),
        .time_left(time_left),
        .expired  (expired)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        errors_d    = errors_q;
        addr_d      = addr_q;
        digit_d     = digit_q;
        timer_load  = 1'b0;
        move_ready  = 1'b0;
        wr_en       = 1'b0;
        rd_addr     = addr_q;

        unique case (state_q)
            StIdle, StWon, StLost: begin
                if (start) begin
                    timer_load  = 1'b1;
                    remaining_d = blanks_init;
                    errors_d    = 2'd0;
                    state_d     = (blanks_init == 7'd0) ? StWon : StPlay;
                end
            end
            StPlay: begin
                move_ready = move_valid;
                rd_addr    = move_addr;
                // Expiry wins over a move offered in the same cycle.
                if (expired) begin
                    state_d = StLost;
                end else if (move_valid && move_ok) begin
                    addr_d  = move_addr;
                    digit_d = move_digit;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                state_d = StJudge;
            end
            StJudge: begin
                state_d = StPlay;
                if (cell_filled) begin
                    state_d = StPlay;
                end else if (sol_digit == digit_q) begin
                    wr_en = 1'b1;
                    if (remaining_q != 7'd0) begin
                        remaining_d = remaining_q - 7'd1;
                    end
                    if (remaining_q <= 7'd1) begin
                        state_d = StWon;
                    end
                end else begin
                    if (errors_q != 2'b11) begin
                        errors_d = errors_q + 2'd1;
                    end
                    if ({30'd0, errors_d} >= MAX_ERRORS) begin
                        state_d = StLost;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        unique case (state_d)
            StWon:   status_d = ST_WON;
            StLost:  status_d = ST_LOST;
            default: status_d = ST_PLAY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            errors_q    <= '0;
            addr_q      <= '0;
            digit_q     <= '0;
            status_q    <= ST_PLAY;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            errors_q    <= errors_d;
            addr_q      <= addr_d;
            digit_q     <= digit_d;
            status_q    <= status_d;
        end
    end

    assign wr_addr    = addr_q;
    assign wr_data    = digit_q;
    assign errors     = errors_q;
    assign status     = status_q;
    assign end_enable = (state_q == StWon) || (state_q == StLost);

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: game-level reference model, write scoreboard and random games.
module tb_game_sequencer;

    localparam int unsigned MaxErr = 3;
    localparam int unsigned Tl     = 2;

    logic       clk, rstn, start, tick, move_valid, cell_filled;
    logic [6:0] blanks_init;
    logic [3:0] move_row, move_col, move_digit, sol_digit;
    logic       move_ready, wr_en, end_enable;
    logic [6:0] rd_addr, wr_addr;
    logic [3:0] wr_data;
    logic [1:0] errors, status;
    logic [9:0] time_left;

    game_sequencer #(
        .MAX_ERRORS(MaxErr),
        .TIME_LIMIT(Tl)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .blanks_init(blanks_init),
        .tick       (tick),
        .move_valid (move_valid),
        .move_row   (move_row),
        .move_col   (move_col),
        .move_digit (move_digit),
        .sol_digit  (sol_digit),
        .cell_filled(cell_filled),
        .move_ready (move_ready),
        .rd_addr    (rd_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .errors     (errors),
        .time_left  (time_left),
        .status     (status),
        .end_enable (end_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board environment: solution ROM and filled flags, 1-cycle read latency.
    logic [3:0] sol_mem [81];
    bit         env_filled [81];
    always @(posedge clk) begin
        sol_digit   <= (rd_addr < 7'd81) ? sol_mem[rd_addr] : 4'd0;
        cell_filled <= (rd_addr < 7'd81) ? env_filled[rd_addr] : 1'b0;
        if (wr_en && wr_addr < 7'd81) env_filled[wr_addr] <= 1'b1;
    end

    // Game-level model.
    typedef enum {MIdle, MPlay, MWon, MLost} mst_t;
    mst_t m_st;
    int   m_rem, m_err, m_time;
    bit   m_filled [81];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit wr;
        int addr;
        int data;
    } exp_t;
    exp_t exp_q[$];
    exp_t pend;
    int   pend_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each accepted move pops its expected outcome, judged two cycles later.
    always @(negedge clk) begin
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                chk("judge wr_en", int'(wr_en), int'(pend.wr));
                if (pend.wr && wr_en) begin
                    chk("wr_addr", int'(wr_addr), pend.addr);
                    chk("wr_data", int'(wr_data), pend.data);
                end
            end else if (wr_en) begin
                chk("stray wr_en", int'(wr_en), 0);
            end
        end else if (wr_en) begin
            chk("stray wr_en", int'(wr_en), 0);
        end
        if (move_valid && move_ready) begin
            chk("accepted move was expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                pend     = exp_q.pop_front();
                pend_cnt = 2;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrong_of(input int s);
        return (s % 9) + 1;
    endfunction

    task automatic chk_status(input string tag);
        int es;
        es = (m_st == MWon) ? 1 : (m_st == MLost) ? 2 : 0;
        chk({tag, " status"}, int'(status), es);
        chk({tag, " end_enable"}, int'(end_enable), int'(m_st == MWon || m_st == MLost));
        chk({tag, " errors"}, int'(errors), m_err);
        chk({tag, " time_left"}, int'(time_left), m_time);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " status"}, int'(status), 0);
        chk({tag, " errors"}, int'(errors), 0);
        chk({tag, " time_left"}, int'(time_left), 0);
        chk({tag, " wr_en"}, int'(wr_en), 0);
        chk({tag, " move_ready"}, int'(move_ready), 0);
        chk({tag, " end_enable"}, int'(end_enable), 0);
        chk({tag, " wr_addr"}, int'(wr_addr), 0);
        chk({tag, " wr_data"}, int'(wr_data), 0);
        chk({tag, " rd_addr"}, int'(rd_addr), 0);
    endtask

    task automatic do_start(input int b);
        start       = 1'b1;
        blanks_init = 7'(b);
        if (m_st != MPlay) begin
            m_rem  = b;
            m_err  = 0;
            m_time = Tl;
            m_st   = (b == 0) ? MWon : MPlay;
        end
        step();
        start = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        if (m_st == MPlay && m_time > 0) m_time--;
        step();
        tick = 1'b0;
        chk("time_left after tick", int'(time_left), m_time);
        if (m_st == MPlay && m_time == 0) begin
            chk("status at expiry cycle", int'(status), 0);
            step();
            m_st = MLost;
        end
    endtask

    // Offers one move and runs it to one cycle past its JUDGE.
    task automatic do_move(input int r, input int c, input int d, input bit tick_judge);
        exp_t e;
        int   a;
        e          = '{wr: 1'b0, addr: 0, data: 0};
        move_valid = 1'b1;
        move_row   = 4'(r);
        move_col   = 4'(c);
        move_digit = 4'(d);
        if (r > 8 || c > 8 || d == 0 || d > 9) begin
            exp_q.push_back(e);
            step();
            move_valid = 1'b0;
            step();
            step();
        end else begin
            a = r * 9 + c;
            if (!m_filled[a] && d == int'(sol_mem[a])) e = '{wr: 1'b1, addr: a, data: d};
            exp_q.push_back(e);
            step();
            move_valid = 1'b0;
            step();
            tick = tick_judge;
            step();
            tick = 1'b0;
            if (tick_judge && m_time > 0) m_time--;
            if (m_filled[a]) begin
                // discarded
            end else if (d == int'(sol_mem[a])) begin
                m_filled[a] = 1'b1;
                m_rem--;
                if (m_rem == 0) m_st = MWon;
            end else begin
                if (m_err < 3) m_err++;
                if (m_err >= int'(MaxErr)) m_st = MLost;
            end
        end
        step();
        if (m_st == MPlay && m_time == 0) m_st = MLost;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c, d, sel;
        rstn = 1'b0; start = 1'b0; tick = 1'b0; blanks_init = '0;
        move_valid = 1'b1; move_row = 4'd2; move_col = 4'd3; move_digit = 4'd5;
        m_st = MIdle; m_rem = 0; m_err = 0; m_time = 0;
        for (int i = 0; i < 81; i++) begin
            sol_mem[i]    = 4'($urandom_range(1, 9));
            env_filled[i] = 1'b0;
            m_filled[i]   = 1'b0;
        end
        sol_mem[21] = 4'd5;
        #3;
        chk_reset_outputs("reset");
        move_valid = 1'b0;
        step();
        rstn = 1'b1;
        step();
        chk_status("after reset");

        // Correct move completes a one-blank board.
        do_start(1);
        chk_status("start");
        do_move(2, 3, 5, 1'b0);
        chk_status("won");

        // Restart from WON; invalid and filled-cell moves change nothing.
        do_start(5);
        chk_status("restart");
        do_move(9, 0, 4, 1'b0);
        do_move(0, 0, 0, 1'b0);
        env_filled[10] = 1'b1;
        m_filled[10]   = 1'b1;
        do_move(1, 1, int'(sol_mem[10]), 1'b0);
        chk_status("invalid moves");
        do_move(3, 0, wrong_of(int'(sol_mem[27])), 1'b0);
        chk_status("one error");
        do_tick();
        do_start(7);
        chk_status("start in play");
        for (int i = 0; i < 4; i++) begin
            do_move(3, i, int'(sol_mem[27 + i]), 1'b0);
            chk_status("blank count");
        end
        do_move(3, 4, int'(sol_mem[31]), 1'b1);
        chk_status("win on expiring tick");

        // Error limit.
        do_start(3);
        for (int i = 0; i < 3; i++) begin
            do_move(4, 0, wrong_of(int'(sol_mem[36])), 1'b0);
            chk_status("wrong move");
        end

        // Start from LOST, then time out.
        do_start(2);
        chk_status("start in lost");
        do_tick();
        chk_status("first tick");
        do_tick();
        chk_status("timeout");
        do_tick();
        chk_status("tick in lost");
        do_start(0);
        chk_status("zero blanks");

        // Reset during LOOKUP aborts the move.
        do_start(1);
        exp_q.push_back('{wr: 1'b0, addr: 0, data: 0});
        move_valid = 1'b1; move_row = 4'd5; move_col = 4'd0; move_digit = sol_mem[45];
        step();
        #1 rstn = 1'b0;
        m_st = MIdle; m_rem = 0; m_err = 0; m_time = 0;
        #1;
        chk_reset_outputs("mid-move reset");
        move_valid = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
        chk_status("after mid-move reset");
        do_start(1);
        do_move(5, 0, int'(sol_mem[45]), 1'b0);
        chk_status("game after reset");

        // Random games.
        for (int g = 0; g < 25; g++) begin
            for (int i = 0; i < 81; i++) begin
                sol_mem[i]    = 4'($urandom_range(1, 9));
                env_filled[i] = ($urandom_range(0, 3) == 0);
                m_filled[i]   = env_filled[i];
            end
            do_start($urandom_range(0, 6));
            chk_status("rand start");
            for (int k = 0; k < 40 && m_st == MPlay; k++) begin
                sel = $urandom_range(0, 99);
                if (sel < 80) begin
                    r = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
                    c = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
                    if (r <= 8 && c <= 8 && $urandom_range(0, 3) != 0) d = int'(sol_mem[r * 9 + c]);
                    else d = $urandom_range(0, 15);
                    do_move(r, c, d, $urandom_range(0, 9) == 0);
                end else if (sel < 88) begin
                    do_tick();
                end else if (sel < 94) begin
                    do_start($urandom_range(1, 6));
                end else begin
                    step();
                end
                chk_status("rand");
            end
        end

        step();
        chk("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_ERRORS, default 3, meaning wrong moves that end the game in a loss.
REQ-002 The block SHALL have parameter TIME_LIMIT, default 600, meaning the game length in tick periods (seconds).
REQ-003 The block SHALL have one clock and one reset, with the following ports:
- clk  in  1  single system clock.
- rstn  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have the following control inputs:
- start  in  1  one-cycle pulse that begins a game.
- blanks_init  in  7  empty-cell count, sampled on start.
- tick  in  1  one-cycle pulse per second.
REQ-005 The block SHALL have the following move inputs:
- move_valid  in  1  move offered.
- move_row  in  4  row, 0..8.
- move_col  in  4  column, 0..8.
- move_digit  in  4  digit, 1..9.
REQ-006 The block SHALL have the following board-read inputs:
- sol_digit  in  4  solution digit at rd_addr, 1-cycle latency.
- cell_filled  in  1  cell already holds a digit, same latency as sol_digit.
REQ-007 The block SHALL have the following outputs:
- move_ready  out  1  move accepted this cycle.
- rd_addr  out  7  board/solution read address.
- wr_en  out  1  board write strobe.
- wr_addr  out  7  write address.
- wr_data  out  4  write digit.
REQ-008 The block SHALL have the following status outputs:
- errors  out  2  wrong-move count.
- time_left  out  10  remaining ticks.
- status  out  2  00 playing/idle, 01 won, 10 lost.
- end_enable  out  1  enables the end-of-game handler.

Function
REQ-009 The FSM states SHALL be IDLE, PLAY, LOOKUP, JUDGE, WON and LOST.
REQ-010 From IDLE, start SHALL load the remaining-cell count from blanks_init, clear errors, set time_left=TIME_LIMIT and go to PLAY.
REQ-011 start SHALL be ignored in PLAY, LOOKUP and JUDGE.
REQ-012 start in WON or LOST SHALL restart the game exactly as from IDLE.
REQ-013 In PLAY, move_ready SHALL equal move_valid; a move is accepted when both are high.
REQ-014 move_ready SHALL be 0 in every state other than PLAY.
REQ-015 An accepted move SHALL be rejected with no side effect, staying in PLAY, if move_row>8, move_col>8, move_digit==0 or move_digit>9.
REQ-016 An accepted valid move SHALL drive rd_addr=move_row*9+move_col (7-bit, max 80), capture the address and digit, and go to LOOKUP.
REQ-017 LOOKUP SHALL last one cycle and then go to JUDGE.
REQ-018 In JUDGE, if cell_filled=1 the move SHALL be discarded with no write and no error, returning to PLAY.
REQ-019 In JUDGE, if the digit matches sol_digit, the block SHALL pulse wr_en for one cycle with the captured address and digit and decrement the remaining-cell count.
REQ-020 If that decrement reaches 0, the block SHALL go to WON; otherwise it SHALL return to PLAY.
REQ-021 In JUDGE, a wrong digit SHALL increment errors (saturating) with no write.
REQ-022 If errors reaches MAX_ERRORS, the block SHALL go to LOST; otherwise it SHALL return to PLAY.
REQ-023 Move latency SHALL be 3 cycles: accept → LOOKUP → JUDGE (wr_en) → next PLAY cycle.
REQ-024 time_left SHALL decrement on each tick in PLAY, LOOKUP and JUDGE, and SHALL saturate at 0.
REQ-025 If time_left reaches 0 in PLAY, the block SHALL go to LOST on the next cycle.
REQ-026 If time_left reaches 0 in LOOKUP or JUDGE, the in-flight move SHALL complete first.
REQ-027 If a move completes the board in the same cycle that time expires, WON SHALL take priority.
REQ-028 The status output SHALL be 00 in IDLE, PLAY, LOOKUP and JUDGE, 01 in WON, and 10 in LOST.
REQ-029 status SHALL be registered and held until start or reset.
REQ-030 end_enable SHALL be 1 exactly in WON and LOST.
REQ-031 If blanks_init==0 at start, the block SHALL go directly to WON.
REQ-032 tick in IDLE, WON or LOST SHALL have no effect.

Reset
REQ-033 On rstn low, the block SHALL asynchronously enter IDLE.
REQ-034 During and after reset, all outputs SHALL be 0: status=00, errors=0, time_left=0, wr_en=0, move_ready=0 and end_enable=0.
REQ-035 On reset, the remaining-cell count SHALL be 0.
REQ-036 A reset in the middle of a move SHALL abort it with no wr_en pulse.

Structure
REQ-037 A shared package SHALL hold:
- the state enum;
- status codes ST_PLAY=2'b00, ST_WON=2'b01, ST_LOST=2'b10;
- constant BOARD_CELLS=81;
- constant BOARD_DIM=9.
REQ-038 The countdown SHALL be a sub-module game_timer with the following behaviour:
- load, run and tick inputs;
- time_left and expired outputs;
- the same reset behaviour as this block.

Verification
REQ-039 Correct move: reset; start with blanks_init=1; move (2,3,5) with sol_digit=5 and cell_filled=0 → wr_en pulse, wr_addr=21, wr_data=5, status=01 and end_enable=1 two cycles after JUDGE.
REQ-040 Error limit: three wrong moves with MAX_ERRORS=3 → errors goes 1, 2, then the block enters LOST with status=10 after the third JUDGE and no wr_en is ever asserted.
REQ-041 Invalid moves: move (9,0,4), then (0,0,0), then a move to a filled cell → no wr_en, errors=0, blanks unchanged, state PLAY.
REQ-042 Timeout: TIME_LIMIT=2; two ticks → time_left=0 and LOST on the next cycle. A final correct move whose JUDGE coincides with the tick that expires time, with blanks=1, → WON.
REQ-043 Mid-move reset: rstn low during LOOKUP → no wr_en, all outputs 0, and a following start runs a normal game.
REQ-044 Start handling: start during PLAY → ignored (time_left and errors preserved); start in LOST → status=00, errors=0, time_left=TIME_LIMIT.
